// File: rtl/decode_stage_p.sv
// decode_stage_p: MIPS decode stage between the F/D register and the E stage.
//   Holds the register file (write-through bypass), forwards from E/M and M/W,
//   resolves branches/jumps in D (with branch-likely nullification), detects
//   load-use / not-ready hazards, and drives the D/E pipeline register.
// Ports:
//   Clk, Reset                  clock, async active-high reset
//   instr_F, pc4_F, valid_F     instruction from F/D
//   stall_in, flush_D           external stall / squash of the D instruction
//   we_W, wa_W, wd_W            register file write port
//   fa_E/fd_E/fr_E              E/M forwarding address, data, ready
//   fa_M/fd_M/fr_M              M/W forwarding address, data, ready
//   stall_D, redirect, npc      hazard hold and fetch redirect
//   nullify_F                   squash the delay slot in F
//   IR_E..valid_E               D/E register outputs
//   stall_cnt                   saturating count of stall cycles
module decode_stage_p #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter logic [XLEN-1:0] RESET_PC4 = 32'h0000_3004,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [31:0]     instr_F,
  input  logic [XLEN-1:0] pc4_F,
  input  logic            valid_F,
  input  logic            stall_in,
  input  logic            flush_D,
  input  logic            we_W,
  input  logic [AW-1:0]   wa_W,
  input  logic [XLEN-1:0] wd_W,
  input  logic [AW-1:0]   fa_E,
  input  logic [XLEN-1:0] fd_E,
  input  logic            fr_E,
  input  logic [AW-1:0]   fa_M,
  input  logic [XLEN-1:0] fd_M,
  input  logic            fr_M,
  output logic            stall_D,
  output logic            redirect,
  output logic [XLEN-1:0] npc,
  output logic            nullify_F,
  output logic [31:0]     IR_E,
  output logic [XLEN-1:0] PC4_E,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] IMM_E,
  output logic            valid_E,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07, OP_ADDIU = 6'h09, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_BEQL  = 6'h14, OP_BNEL = 6'h15, OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B, FN_JR   = 6'h08;

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     ir_e_q;
  logic [XLEN-1:0] pc4_e_q, rd1_e_q, rd2_e_q, imm_e_q;
  logic            valid_e_q;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]      op, fn;
  logic [15:0]     imm16;
  logic [AW-1:0]   rs_a, rt_a;
  logic            is_j, is_jal, is_jr, is_eq, is_ne, is_blez, is_bgtz;
  logic            is_branch, is_likely, use_rs, use_rt, hz_rs, hz_rt, hz;
  logic            eq, cond, go;
  logic [XLEN-1:0] rf_rs, rf_rt, rs_val, rt_val, imm_sext, imm_ext;
  logic [XLEN-1:0] br_target, j_target;

  assign op    = instr_F[31:26];
  assign fn    = instr_F[5:0];
  assign imm16 = instr_F[15:0];
  assign rs_a  = instr_F[21 +: AW];
  assign rt_a  = instr_F[16 +: AW];

  assign is_j      = (op == OP_J);
  assign is_jal    = (op == OP_JAL);
  assign is_jr     = (op == OP_RTYPE) && (fn == FN_JR);
  assign is_eq     = (op == OP_BEQ) || (op == OP_BEQL);
  assign is_ne     = (op == OP_BNE) || (op == OP_BNEL);
  assign is_blez   = (op == OP_BLEZ);
  assign is_bgtz   = (op == OP_BGTZ);
  assign is_branch = is_eq || is_ne || is_blez || is_bgtz;
  assign is_likely = (op == OP_BEQL) || (op == OP_BNEL);

  // lui carries no rs; stores and loads live in the op[5] half of the map.
  assign use_rs = is_branch || is_jr || ((op[5:3] == 3'b001) && (op != OP_LUI)) || op[5];
  assign use_rt = is_eq || is_ne || (op == OP_SW);

  // Write-through: a same-cycle W write is visible to the D read.
  assign rf_rs = (we_W && (wa_W == rs_a)) ? wd_W : regs_q[rs_a];
  assign rf_rt = (we_W && (wa_W == rt_a)) ? wd_W : regs_q[rt_a];

  always_comb begin
    if (rs_a == '0)        rs_val = '0;
    else if (rs_a == fa_E) rs_val = fd_E;
    else if (rs_a == fa_M) rs_val = fd_M;
    else                   rs_val = rf_rs;
    if (rt_a == '0)        rt_val = '0;
    else if (rt_a == fa_E) rt_val = fd_E;
    else if (rt_a == fa_M) rt_val = fd_M;
    else                   rt_val = rf_rt;
  end

  assign hz_rs = use_rs && (rs_a != '0) &&
                 (((rs_a == fa_E) && !fr_E) || ((rs_a == fa_M) && !fr_M));
  assign hz_rt = use_rt && (rt_a != '0) &&
                 (((rt_a == fa_E) && !fr_E) || ((rt_a == fa_M) && !fr_M));
  assign hz      = valid_F && (hz_rs || hz_rt);
  assign stall_D = valid_F && (hz || stall_in);

  assign imm_sext = XLEN'($signed(imm16));

  always_comb begin
    if (is_jal)
      imm_ext = pc4_F + XLEN'(4);
    else if (op == OP_LUI)
      imm_ext = XLEN'({imm16, 16'h0000});
    else if (is_branch || (op == OP_ADDIU) || (op == OP_LW) || (op == OP_SW))
      imm_ext = imm_sext;
    else
      imm_ext = XLEN'(imm16);
  end

  assign eq   = (rs_val == rt_val);
  assign cond = (is_eq && eq) || (is_ne && !eq) ||
                (is_blez && (rs_val[XLEN-1] || (rs_val == '0))) ||
                (is_bgtz && !rs_val[XLEN-1] && (rs_val != '0));

  assign br_target = pc4_F + (imm_sext << 2);
  assign j_target  = {pc4_F[XLEN-1:28], instr_F[25:0], 2'b00};

  assign go        = valid_F && !stall_D && !flush_D;
  assign redirect  = go && (is_j || is_jal || is_jr || cond);
  assign nullify_F = go && is_likely && !cond;

  always_comb begin
    if (!redirect)            npc = '0;
    else if (is_jr)           npc = rs_val;
    else if (is_j || is_jal)  npc = j_target;
    else                      npc = br_target;
  end

  assign stall_cnt_d = (stall_D && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_W && (wa_W != '0)) begin
      regs_q[wa_W] <= wd_W;
    end
  end

  // Flush wins over stall; both insert a bubble while PC4_E holds.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir_e_q      <= '0;
      pc4_e_q     <= RESET_PC4;
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      imm_e_q     <= '0;
      valid_e_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (flush_D || stall_D) begin
        ir_e_q    <= '0;
        rd1_e_q   <= '0;
        rd2_e_q   <= '0;
        imm_e_q   <= '0;
        valid_e_q <= 1'b0;
      end else begin
        ir_e_q    <= instr_F;
        pc4_e_q   <= pc4_F;
        rd1_e_q   <= rs_val;
        rd2_e_q   <= rt_val;
        imm_e_q   <= imm_ext;
        valid_e_q <= valid_F;
      end
    end
  end

  assign IR_E      = ir_e_q;
  assign PC4_E     = pc4_e_q;
  assign RD1_E     = rd1_e_q;
  assign RD2_E     = rd2_e_q;
  assign IMM_E     = imm_e_q;
  assign valid_E   = valid_e_q;
  assign stall_cnt = stall_cnt_q;

endmodule
